// File: rtl/dmem_bus_if.sv
// dmem_bus_if: memory-stage to request/acknowledge data bus bridge.
// Define DMEM_POSTED_WRITE_EN to add a FIFO of posted writes.
module dmem_bus_if #(
    parameter int ADDR_W     = 16,
    parameter int WBUF_DEPTH = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              WriteL,
    input  logic              WriteR,
    input  logic [31:0]       WriteData,
    output logic [31:0]       MemData,
    output logic              Hold,
    output logic              BusReq,
    output logic              BusWe,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [3:0]        BusBe,
    output logic [31:0]       BusWData,
    input  logic [31:0]       BusRData,
    input  logic              BusAck
);
    typedef enum logic [2:0] {IDLE, RD, WR, RDONE, WDONE} state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              hold;
    logic              ack;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        wr_be;

    assign ack       = BusAck & bus_req_q;
    assign word_addr = {MemAddr[ADDR_W-1:2], 2'b00};

    // Big-endian lanes: BusBe[3] is the byte at offset 0.
    always_comb begin
        wr_be = 4'b1111;
        if (WriteL && !WriteR) begin
            unique case (MemAddr[1:0])
                2'd0: wr_be = 4'b1111;
                2'd1: wr_be = 4'b0111;
                2'd2: wr_be = 4'b0011;
                2'd3: wr_be = 4'b0001;
            endcase
        end else if (WriteR && !WriteL) begin
            unique case (MemAddr[1:0])
                2'd0: wr_be = 4'b1000;
                2'd1: wr_be = 4'b1100;
                2'd2: wr_be = 4'b1110;
                2'd3: wr_be = 4'b1111;
            endcase
        end
    end

`ifdef DMEM_POSTED_WRITE_EN
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
    logic [3:0]        wb_be_q   [WBUF_DEPTH];
    logic [3:0]        wb_be_d   [WBUF_DEPTH];
    logic [31:0]       wb_data_q [WBUF_DEPTH];
    logic [31:0]       wb_data_d [WBUF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_taken_q, wr_taken_d;
    logic              full, empty, enq, pop;

    assign full  = (cnt_q == CW'(WBUF_DEPTH));
    assign empty = (cnt_q == '0);
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        mem_data_d  = mem_data_q;
        hold        = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_taken_d = 1'b0;
        enq        = 1'b0;
        pop        = (state_q == WR) && ack;

        // A stalled write enqueues on the freeing ack; release next cycle.
        if (wr_taken_q) begin
            hold = 1'b0;
        end else if (MemWrite) begin
            enq        = !full || pop;
            hold       = full;
            wr_taken_d = full && pop;
        end else if (MemRead) begin
            hold = (state_q != RDONE);
        end

        if (enq) begin
            wb_addr_d[wr_ptr_q] = word_addr;
            wb_be_d[wr_ptr_q]   = wr_be;
            wb_data_d[wr_ptr_q] = WriteData;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(enq) - CW'(pop);

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d     = WR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = wb_addr_q[rd_ptr_q];
                    bus_be_d    = wb_be_q[rd_ptr_q];
                    bus_wdata_d = wb_data_q[rd_ptr_q];
                end else if (MemRead && !MemWrite) begin
                    state_d    = RD;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = word_addr;
                    bus_be_d   = 4'b1111;
                end
            end
            RD: begin
                if (ack) begin
                    mem_data_d = BusRData;
                    bus_req_d  = 1'b0;
                    state_d    = RDONE;
                end
            end
            WR: begin
                if (ack) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RDONE, WDONE: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
`else
        unique case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    hold        = 1'b1;
                    state_d     = WR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = word_addr;
                    bus_be_d    = wr_be;
                    bus_wdata_d = WriteData;
                end else if (MemRead) begin
                    hold       = 1'b1;
                    state_d    = RD;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = word_addr;
                    bus_be_d   = 4'b1111;
                end
            end
            RD: begin
                hold = 1'b1;
                if (ack) begin
                    mem_data_d = BusRData;
                    bus_req_d  = 1'b0;
                    state_d    = RDONE;
                end
            end
            WR: begin
                hold = 1'b1;
                if (ack) begin
                    bus_req_d = 1'b0;
                    state_d   = WDONE;
                end
            end
            RDONE, WDONE: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            mem_data_q  <= '0;
`ifdef DMEM_POSTED_WRITE_EN
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_taken_q <= 1'b0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_be_q[i]   <= '0;
                wb_data_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            mem_data_q  <= mem_data_d;
`ifdef DMEM_POSTED_WRITE_EN
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wr_taken_q <= wr_taken_d;
            wb_addr_q  <= wb_addr_d;
            wb_be_q    <= wb_be_d;
            wb_data_q  <= wb_data_d;
`endif
        end
    end

    assign Hold     = hold & ~Reset;
    assign BusReq   = bus_req_q;
    assign BusWe    = bus_we_q;
    assign BusAddr  = bus_addr_q;
    assign BusBe    = bus_be_q;
    assign BusWData = bus_wdata_q;
    assign MemData  = mem_data_q;
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed checks of the data-memory bus bridge.
// Posted-write scenarios run only when DMEM_POSTED_WRITE_EN is defined.
module tb_dmem_bus_if;
    localparam int ADDR_W = 16;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRead, MemWrite, WriteL, WriteR;
    logic [31:0]       WriteData;
    logic [31:0]       MemData;
    logic              Hold, BusReq, BusWe;
    logic [ADDR_W-1:0] BusAddr;
    logic [3:0]        BusBe;
    logic [31:0]       BusWData, BusRData;
    logic              BusAck;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    dmem_bus_if #(.ADDR_W(ADDR_W), .WBUF_DEPTH(2)) dut (
        .Clock(Clock), .Reset(Reset), .MemAddr(MemAddr),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .WriteL(WriteL), .WriteR(WriteR), .WriteData(WriteData),
        .MemData(MemData), .Hold(Hold), .BusReq(BusReq),
        .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
        .BusWData(BusWData), .BusRData(BusRData), .BusAck(BusAck)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; MemAddr = '0; MemRead = 0; MemWrite = 0;
        WriteL = 0; WriteR = 0; WriteData = '0; BusRData = '0; BusAck = 0;
        tick; tick;
        Reset = 1'b0;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b0) begin tests_failed++; $display("FAIL rst_hold got %b want 0", Hold); end
        tests_run++;
        if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b want 0", BusReq); end
        tests_run++;
        if (BusWe !== 1'b0) begin tests_failed++; $display("FAIL rst_we got %b want 0", BusWe); end
        tests_run++;
        if (BusAddr !== 16'h0) begin tests_failed++; $display("FAIL rst_addr got %h want 0", BusAddr); end
        tests_run++;
        if (BusBe !== 4'h0) begin tests_failed++; $display("FAIL rst_be got %b want 0", BusBe); end
        tests_run++;
        if (BusWData !== 32'h0) begin tests_failed++; $display("FAIL rst_wdata got %h want 0", BusWData); end
        tests_run++;
        if (MemData !== 32'h0) begin tests_failed++; $display("FAIL rst_mdata got %h want 0", MemData); end
        tick;
    endtask

    task automatic test_read_immediate;
        MemRead = 1; MemAddr = 16'h0010;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b1) begin tests_failed++; $display("FAIL rdi_hold_t0 got %b want 1", Hold); end
        tick;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b1) begin tests_failed++; $display("FAIL rdi_hold_t1 got %b want 1", Hold); end
        tests_run++;
        if (BusReq !== 1'b1) begin tests_failed++; $display("FAIL rdi_req got %b want 1", BusReq); end
        tests_run++;
        if (BusAddr !== 16'h0010) begin tests_failed++; $display("FAIL rdi_addr got %h want 0010", BusAddr); end
        tests_run++;
        if (BusBe !== 4'b1111) begin tests_failed++; $display("FAIL rdi_be got %b want 1111", BusBe); end
        tests_run++;
        if (BusWe !== 1'b0) begin tests_failed++; $display("FAIL rdi_we got %b want 0", BusWe); end
        BusAck = 1; BusRData = 32'hDEADBEEF;
        tick;
        BusAck = 0;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b0) begin tests_failed++; $display("FAIL rdi_hold_t2 got %b want 0", Hold); end
        tests_run++;
        if (MemData !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rdi_data got %h want deadbeef", MemData); end
        tests_run++;
        if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL rdi_req_drop got %b want 0", BusReq); end
        tick;
        MemRead = 0;
        tick;
    endtask

    task automatic test_store_lr;
        logic [15:0] addr_v [2];
        logic [3:0]  be_v [2];
        logic [31:0] dat_v [2];
        bit found;
        addr_v[0] = 16'h0021; be_v[0] = 4'b0111; dat_v[0] = 32'h00AABBCC;
        addr_v[1] = 16'h0022; be_v[1] = 4'b1110; dat_v[1] = 32'h11223300;
        for (int i = 0; i < 2; i++) begin
            MemWrite = 1; WriteL = (i == 0); WriteR = (i == 1);
            MemAddr = addr_v[i]; WriteData = dat_v[i];
            @(negedge Clock);
            tests_run++;
`ifdef DMEM_POSTED_WRITE_EN
            if (Hold !== 1'b0) begin tests_failed++; $display("FAIL st%0d_hold got %b want 0", i, Hold); end
            tick;
            MemWrite = 0; WriteL = 0; WriteR = 0;
`else
            if (Hold !== 1'b1) begin tests_failed++; $display("FAIL st%0d_hold got %b want 1", i, Hold); end
            tick;
`endif
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge Clock);
                if (BusReq === 1'b1) found = 1;
                else tick;
            end
            tests_run++;
            if (!found) begin tests_failed++; $display("FAIL st%0d_req got timeout want BusReq", i); end
            tests_run++;
            if (BusAddr !== 16'h0020) begin tests_failed++; $display("FAIL st%0d_addr got %h want 0020", i, BusAddr); end
            tests_run++;
            if (BusBe !== be_v[i]) begin tests_failed++; $display("FAIL st%0d_be got %b want %b", i, BusBe, be_v[i]); end
            tests_run++;
            if (BusWe !== 1'b1) begin tests_failed++; $display("FAIL st%0d_we got %b want 1", i, BusWe); end
            tests_run++;
            if (BusWData !== dat_v[i]) begin tests_failed++; $display("FAIL st%0d_wdata got %h want %h", i, BusWData, dat_v[i]); end
            BusAck = 1;
            tick;
            BusAck = 0;
            @(negedge Clock);
            tests_run++;
            if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL st%0d_req_drop got %b want 0", i, BusReq); end
            tests_run++;
            if (Hold !== 1'b0) begin tests_failed++; $display("FAIL st%0d_release got %b want 0", i, Hold); end
            tick;
            MemWrite = 0; WriteL = 0; WriteR = 0;
            tick;
        end
    endtask

    task automatic test_read_delayed;
        int holds;
        int unstable;
        holds = 0; unstable = 0;
        MemAddr = 16'h0036; BusRData = 32'hCAFEF00D;
        for (int c = 0; c < 8; c++) begin
            MemRead = 1;
            BusAck = (c == 6);
            @(negedge Clock);
            if (Hold === 1'b1) holds++;
            if (c >= 1 && c <= 6) begin
                if (!(BusReq === 1'b1 && BusAddr === 16'h0034 &&
                      BusBe === 4'b1111 && BusWe === 1'b0)) unstable++;
            end
            if (c == 7) begin
                tests_run++;
                if (Hold !== 1'b0) begin tests_failed++; $display("FAIL rdd_hold_fall got %b want 0", Hold); end
                tests_run++;
                if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL rdd_req_drop got %b want 0", BusReq); end
                tests_run++;
                if (MemData !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL rdd_data got %h want cafef00d", MemData); end
            end
            tick;
        end
        MemRead = 0; BusAck = 0;
        tests_run++;
        if (holds != 7) begin tests_failed++; $display("FAIL rdd_hold_cycles got %0d want 7", holds); end
        tests_run++;
        if (unstable != 0) begin tests_failed++; $display("FAIL rdd_bus_stable got %0d bad cycles want 0", unstable); end
        tick;
    endtask

`ifdef DMEM_POSTED_WRITE_EN
    task automatic test_posted_burst;
        logic [7:0]  hold_seen;
        logic [15:0] log_a [3];
        logic [31:0] log_d [3];
        int nwr;
        int age;
        hold_seen = '0; nwr = 0; age = 0;
        for (int c = 0; c < 40; c++) begin
            MemWrite = 1; WriteL = 0; WriteR = 0;
            if (c == 0) begin MemAddr = 16'h0051; WriteData = 32'hA0A0A0A0; end
            else if (c == 1) begin MemAddr = 16'h0054; WriteData = 32'hB1B1B1B1; end
            else if (c <= 6) begin MemAddr = 16'h0058; WriteData = 32'hC2C2C2C2; end
            else MemWrite = 0;
            if (BusReq === 1'b1) begin
                BusAck = (age == 3);
                if (BusAck && nwr < 3) begin
                    log_a[nwr] = BusAddr; log_d[nwr] = BusWData; nwr++;
                end
                age++;
            end else begin
                BusAck = 0; age = 0;
            end
            @(negedge Clock);
            if (c < 8) hold_seen[c] = Hold;
            tick;
        end
        BusAck = 0;
        tests_run++;
        if (hold_seen !== 8'h3C) begin tests_failed++; $display("FAIL pw_hold_pattern got %b want 00111100", hold_seen); end
        tests_run++;
        if (nwr != 3) begin tests_failed++; $display("FAIL pw_count got %0d want 3", nwr); end
        if (nwr == 3) begin
            tests_run++;
            if (log_a[0] !== 16'h0050 || log_d[0] !== 32'hA0A0A0A0) begin tests_failed++; $display("FAIL pw_order0 got %h/%h want 0050/a0a0a0a0", log_a[0], log_d[0]); end
            tests_run++;
            if (log_a[1] !== 16'h0054 || log_d[1] !== 32'hB1B1B1B1) begin tests_failed++; $display("FAIL pw_order1 got %h/%h want 0054/b1b1b1b1", log_a[1], log_d[1]); end
            tests_run++;
            if (log_a[2] !== 16'h0058 || log_d[2] !== 32'hC2C2C2C2) begin tests_failed++; $display("FAIL pw_order2 got %h/%h want 0058/c2c2c2c2", log_a[2], log_d[2]); end
        end
    endtask

    task automatic test_posted_raw;
        logic [31:0] mem_word;
        logic [31:0] md;
        bit done, wr_acked, order_bad;
        int age;
        mem_word = '0; md = '0; done = 0; wr_acked = 0; order_bad = 0; age = 0;
        MemWrite = 1; WriteL = 0; WriteR = 0;
        MemAddr = 16'h0040; WriteData = 32'h11223344;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b0) begin tests_failed++; $display("FAIL raw_wr_hold got %b want 0", Hold); end
        tick;
        MemWrite = 0; MemRead = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            BusAck = 0;
            if (BusReq === 1'b1) begin
                if (age == 1) begin
                    BusAck = 1;
                    if (BusWe) begin
                        mem_word = BusWData; wr_acked = 1;
                    end else begin
                        if (!wr_acked) order_bad = 1;
                        BusRData = (BusAddr == 16'h0040) ? mem_word : 32'h0;
                    end
                end
                age++;
            end else begin
                age = 0;
            end
            @(negedge Clock);
            if (c == 0) begin
                tests_run++;
                if (Hold !== 1'b1) begin tests_failed++; $display("FAIL raw_rd_wait got %b want 1", Hold); end
            end else if (Hold === 1'b0) begin
                done = 1; md = MemData;
            end
            tick;
        end
        MemRead = 0; BusAck = 0;
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL raw_done got timeout want Hold fall"); end
        tests_run++;
        if (!wr_acked || order_bad) begin tests_failed++; $display("FAIL raw_order got wr_acked=%0b read_first=%0b want 1/0", wr_acked, order_bad); end
        tests_run++;
        if (md !== 32'h11223344) begin tests_failed++; $display("FAIL raw_data got %h want 11223344", md); end
        tick;
    endtask
`endif

    task automatic test_reset_mid;
        MemRead = 1; MemAddr = 16'h0044;
        tick;
        @(negedge Clock);
        tests_run++;
        if (BusReq !== 1'b1) begin tests_failed++; $display("FAIL rm_pre_req got %b want 1", BusReq); end
        Reset = 1;
        tick;
        Reset = 0; MemRead = 0; BusAck = 1; BusRData = 32'hFFFFFFFF;
        @(negedge Clock);
        tests_run++;
        if (Hold !== 1'b0) begin tests_failed++; $display("FAIL rm_hold got %b want 0", Hold); end
        tests_run++;
        if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL rm_req got %b want 0", BusReq); end
        tests_run++;
        if (BusWe !== 1'b0) begin tests_failed++; $display("FAIL rm_we got %b want 0", BusWe); end
        tests_run++;
        if (BusAddr !== 16'h0) begin tests_failed++; $display("FAIL rm_addr got %h want 0", BusAddr); end
        tests_run++;
        if (BusBe !== 4'h0) begin tests_failed++; $display("FAIL rm_be got %b want 0", BusBe); end
        tests_run++;
        if (BusWData !== 32'h0) begin tests_failed++; $display("FAIL rm_wdata got %h want 0", BusWData); end
        tests_run++;
        if (MemData !== 32'h0) begin tests_failed++; $display("FAIL rm_mdata got %h want 0", MemData); end
        tick;
        BusAck = 0;
        @(negedge Clock);
        tests_run++;
        if (BusReq !== 1'b0) begin tests_failed++; $display("FAIL rm_stray_req got %b want 0", BusReq); end
        tests_run++;
        if (Hold !== 1'b0) begin tests_failed++; $display("FAIL rm_stray_hold got %b want 0", Hold); end
        tests_run++;
        if (MemData !== 32'h0) begin tests_failed++; $display("FAIL rm_stray_mdata got %h want 0", MemData); end
        tick;
    endtask

    initial begin
        test_reset();
        test_read_immediate();
        test_store_lr();
        test_read_delayed();
`ifdef DMEM_POSTED_WRITE_EN
        test_posted_burst();
        test_posted_raw();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
